// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART receiver and transmitter.
//   uart_state_t : 2-bit frame state encoding (IDLE, START, DATA, STOP).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Two-flop synchronizer bringing the asynchronous serial line into the clk
//   domain. Both flops reset to 1 so an idle (high) line never looks like a
//   start edge coming out of reset.
// Ports
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   d    in   asynchronous input
//   q    out  synchronized output
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
//   UART receiver: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit,
//   no parity. Bit timing comes from a shared tick at OVERSAMPLE_RATE x baud;
//   each bit is sampled at its mid-point.
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   tick         in   one-clk strobe at OVERSAMPLE_RATE x baud
//   rx_in        in   asynchronous serial line, idle high
//   rx_out       out  last good received word, held until the next good frame
//   rx_dv        out  one-clk pulse: rx_out updated this cycle
//   framing_err  out  one-clk pulse: stop bit sampled low, frame dropped
//   rx_busy      out  high whenever a frame is in progress
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int OVERSAMPLE_RATE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_out,
  output logic                  rx_dv,
  output logic                  framing_err,
  output logic                  rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE_RATE);
  localparam int BW = $clog2(DATA_WIDTH) + 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE_RATE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE_RATE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  logic rx_s;
  logic rx_prev;
  logic fall;

  uart_state_t           state, state_nxt;
  logic [TW-1:0]         tick_cnt, tick_cnt_nxt;
  logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic [DATA_WIDTH-1:0] rx_out_nxt;
  logic                  rx_dv_nxt;
  logic                  framing_err_nxt;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  // Only a high->low transition starts a frame, so a held-low (break) line
  // cannot retrigger the receiver after a framing error.
  assign fall    = rx_prev & ~rx_s;
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rx_prev     <= 1'b1;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_out      <= '0;
      rx_dv       <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rx_prev     <= rx_s;
      tick_cnt    <= tick_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shift       <= shift_nxt;
      rx_out      <= rx_out_nxt;
      rx_dv       <= rx_dv_nxt;
      framing_err <= framing_err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    tick_cnt_nxt    = tick_cnt;
    bit_cnt_nxt     = bit_cnt;
    shift_nxt       = shift;
    rx_out_nxt      = rx_out;
    rx_dv_nxt       = 1'b0;
    framing_err_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        // A tick in the same cycle as the edge is deliberately not counted.
        if (fall) begin
          state_nxt    = START;
          tick_cnt_nxt = '0;
        end
      end

      START: begin
        if (tick) begin
          if (tick_cnt == TICK_HALF) begin
            if (!rx_s) begin
              state_nxt    = DATA;
              tick_cnt_nxt = '0;
              bit_cnt_nxt  = '0;
            end else begin
              // Line back high at mid-start: treat as a glitch.
              state_nxt = IDLE;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + TW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            shift_nxt    = {rx_s, shift[DATA_WIDTH-1:1]};
            tick_cnt_nxt = '0;
            if (bit_cnt == BIT_LAST) begin
              state_nxt = STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + BW'(1);
            end
          end else begin
            tick_cnt_nxt = tick_cnt + TW'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            // Return to IDLE at stop mid-bit so a back-to-back start edge,
            // half a bit later, is still caught.
            if (rx_s) begin
              rx_out_nxt = shift;
              rx_dv_nxt  = 1'b1;
            end else begin
              framing_err_nxt = 1'b1;
            end
            state_nxt    = IDLE;
            tick_cnt_nxt = '0;
          end else begin
            tick_cnt_nxt = tick_cnt + TW'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Scoreboard bench for uart_receiver: stimulus pushes the expected result
//   of each frame (data word or framing error) into a queue; an independent
//   monitor pops and compares whenever rx_dv or framing_err pulses.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_out;
  logic       rx_dv;
  logic       framing_err;
  logic       rx_busy;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tick_div = 4;
  int   tcnt     = 0;

  uart_receiver #(.DATA_WIDTH(8), .OVERSAMPLE_RATE(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .rx_in       (rx_in),
    .rx_out      (rx_out),
    .rx_dv       (rx_dv),
    .framing_err (framing_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  // Baud tick: one clk high every tick_div clocks.
  initial begin
    forever begin
      @(negedge clk);
      if (tcnt >= tick_div - 1) begin
        tcnt = 0;
        tick = 1'b1;
      end else begin
        tcnt++;
        tick = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (rx_dv || framing_err)) begin
        check("dv_and_err_exclusive", {31'd0, rx_dv & framing_err}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, rx_dv, framing_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {31'd0, framing_err}, {31'd0, e.is_err});
          if (!e.is_err) check("rx_out", {24'd0, rx_out}, {24'd0, e.data});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int bit_clk();
    return 16 * tick_div;
  endfunction

  task automatic send(input logic [7:0] d, input logic stop_bit);
    rx_in = 1'b0;
    hold(bit_clk());
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      hold(bit_clk());
    end
    rx_in = stop_bit;
    hold(bit_clk());
  endtask

  task automatic expect_data(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [7:0] rnd;

    // Reset state
    hold(5);
    rst = 1'b0;
    hold(2);
    check("reset_rx_out", {24'd0, rx_out}, 32'h0);
    check("reset_rx_dv", {31'd0, rx_dv}, 32'd0);
    check("reset_framing_err", {31'd0, framing_err}, 32'd0);
    check("reset_busy", {31'd0, rx_busy}, 32'd0);
    hold(20);

    // 1: single good frame
    expect_data(8'hA5);
    send(8'hA5, 1'b1);
    hold(bit_clk());
    check("t1_rx_out_held", {24'd0, rx_out}, 32'hA5);
    check("t1_busy_idle", {31'd0, rx_busy}, 32'd0);

    // 2: 5-tick glitch is a false start
    rx_in = 1'b0;
    hold(5 * tick_div);
    check("t2_busy_during_glitch", {31'd0, rx_busy}, 32'd1);
    rx_in = 1'b1;
    hold(2 * bit_clk());
    check("t2_busy_dropped", {31'd0, rx_busy}, 32'd0);
    check("t2_rx_out_kept", {24'd0, rx_out}, 32'hA5);

    // 3: framing error, line then held low for 20 bit times
    expect_err();
    send(8'h3C, 1'b0);
    hold(19 * bit_clk());
    check("t3_no_restart_on_break", {31'd0, rx_busy}, 32'd0);
    check("t3_rx_out_kept", {24'd0, rx_out}, 32'hA5);
    rx_in = 1'b1;
    hold(2 * bit_clk());
    check("t3_still_idle", {31'd0, rx_busy}, 32'd0);

    // 4: back-to-back frames, no idle gap
    expect_data(8'h00);
    expect_data(8'hFF);
    expect_data(8'h55);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h55, 1'b1);
    hold(bit_clk());
    check("t4_last_value", {24'd0, rx_out}, 32'h55);
    check("t4_pending", exp_q.size(), 32'd0);

    // 5: reset in the middle of data bit 4 aborts the frame
    rx_in = 1'b0;
    hold(bit_clk());
    rx_in = 1'b1;
    hold(4 * bit_clk() + bit_clk() / 2);
    check("t5_busy_before_rst", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(2);
    check("t5_rx_out_zero", {24'd0, rx_out}, 32'h0);
    check("t5_busy_zero", {31'd0, rx_busy}, 32'd0);
    hold(2 * bit_clk());
    check("t5_no_pulse_idle", {30'd0, rx_dv, framing_err}, 32'd0);
    expect_data(8'h81);
    send(8'h81, 1'b1);
    hold(bit_clk());
    check("t5_after_rst_rx_out", {24'd0, rx_out}, 32'h81);

    // 6: 256 random bytes through a serializer sharing the same tick
    tick_div = 1;
    hold(bit_clk());
    for (int i = 0; i < 256; i++) begin
      rnd = 8'($urandom_range(0, 255));
      expect_data(rnd);
      send(rnd, 1'b1);
    end
    hold(4 * bit_clk());

    check("final_pending", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, rx_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
